sample_walker: RTL and testbench

- Sample iterator for the raster pipe, one stage upstream of the sample test.
- Accepts one triangle at a time with its colour and its snapped bounding box.
- Walks every sample location inside the box in raster order, inclusive of both corners.
- Each cycle, drives the triangle, the colour and the current sample location with a valid flag into the sample test. Holds off the upstream bounding-box stage with a halt signal while walking.

---
 rtl/sample_walker.sv | 93 +++++++++
 tb/tb_sample_walker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_walker.sv
// Raster sample iterator: captures one triangle and its snapped bounding box,
// then walks every step-grid sample in the box in x-major, bottom-to-top order.
//
//   state | meaning
//   WAIT  | idle, no valid sample on the outputs, ready to accept
//   TEST  | emitting one sample per cycle for the captured triangle
`timescale 1ns/1ps
module sample_walker #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]      tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]               color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]                 box_R13S,
  input  logic                                        validTri_R13H,
  input  logic [1:0]                                  ss_lg2_R13U,
  output logic                                        halt_RnnnnH,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]      tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]               color_R14U,
  output logic [1:0][SIGFIG-1:0]                      sample_R14S,
  output logic                                        validSamp_R14H
);

  typedef enum logic {WAIT, TEST} state_t;

  state_t            state, state_nxt;
  logic [SIGFIG-1:0] ll_x, ur_x, ur_y, step, step_in;
  logic signed [SIGFIG:0] nx, ny;
  logic              x_over, y_over, last, accept, degen;

  assign step_in = SIGFIG'(1) << (RADIX - 32'(ss_lg2_R13U));

  // One extra bit keeps x+step from wrapping at the positive coordinate limit.
  assign nx = $signed({sample_R14S[0][SIGFIG-1], sample_R14S[0]}) + $signed({1'b0, step});
  assign ny = $signed({sample_R14S[1][SIGFIG-1], sample_R14S[1]}) + $signed({1'b0, step});
  assign x_over = nx > $signed({ur_x[SIGFIG-1], ur_x});
  assign y_over = ny > $signed({ur_y[SIGFIG-1], ur_y});
  assign last   = x_over && y_over;

  // An inverted box on either axis collapses to a single sample at ll.
  assign degen = ($signed(box_R13S[1][0]) < $signed(box_R13S[0][0])) ||
                 ($signed(box_R13S[1][1]) < $signed(box_R13S[0][1]));

  assign validSamp_R14H = (state == TEST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    halt_RnnnnH = 1'b0;
    accept      = 1'b0;
    state_nxt   = state;
    if (state == TEST && !last) halt_RnnnnH = 1'b1;
    accept = validTri_R13H && !halt_RnnnnH;
    if (accept)                        state_nxt = TEST;
    else if (state == TEST && last)    state_nxt = WAIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tri_R14S    <= '0;
      color_R14U  <= '0;
      sample_R14S <= '0;
      ll_x        <= '0;
      ur_x        <= '0;
      ur_y        <= '0;
      step        <= '0;
    end else if (accept) begin
      tri_R14S    <= tri_R13S;
      color_R14U  <= color_R13U;
      sample_R14S <= box_R13S[0];
      ll_x        <= box_R13S[0][0];
      ur_x        <= degen ? box_R13S[0][0] : box_R13S[1][0];
      ur_y        <= degen ? box_R13S[0][1] : box_R13S[1][1];
      step        <= step_in;
    end else if (state == TEST && !last) begin
      if (x_over) begin
        sample_R14S[0] <= ll_x;
        sample_R14S[1] <= ny[SIGFIG-1:0];
      end else begin
        sample_R14S[0] <= nx[SIGFIG-1:0];
      end
    end
  end

endmodule

// File: tb/tb_sample_walker.sv
// Directed bench for sample_walker: walk order, halt timing, back-to-back
// hand-off, halt-time input masking and asynchronous reset.
`timescale 1ns/1ps
module tb_sample_walker;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [2:0][2:0][23:0]  tri_in, tri_out;
  logic [2:0][23:0]       col_in, col_out;
  logic [1:0][1:0][23:0]  box;
  logic                   valid_tri;
  logic [1:0]             ss;
  logic                   halt;
  logic [1:0][23:0]       sample;
  logic                   valid_samp;

  int tests = 0;
  int fails = 0;
  logic [23:0] qx[$];
  logic [23:0] qy[$];

  localparam logic [215:0] TRI_A = {9{24'h123456}};
  localparam logic [215:0] TRI_B = {9{24'h0FEDCB}};
  localparam logic [215:0] TRI_C = {9{24'h00A5A5}};
  localparam logic [71:0]  COL_A = {3{24'h0ABCDE}};
  localparam logic [71:0]  COL_B = {3{24'h111111}};
  localparam logic [71:0]  COL_C = {3{24'h777777}};

  sample_walker dut (
    .clk(clk), .rst(rst),
    .tri_R13S(tri_in), .color_R13U(col_in), .box_R13S(box),
    .validTri_R13H(valid_tri), .ss_lg2_R13U(ss),
    .halt_RnnnnH(halt), .tri_R14S(tri_out), .color_R14U(col_out),
    .sample_R14S(sample), .validSamp_R14H(valid_samp)
  );

  always #5 clk = ~clk;

  task automatic present(input int llx, input int lly, input int urx, input int ury,
                         input logic [1:0] s, input logic [215:0] t, input logic [71:0] c);
    box[0][0] = 24'(llx); box[0][1] = 24'(lly);
    box[1][0] = 24'(urx); box[1][1] = 24'(ury);
    ss = s; tri_in = t; col_in = c; valid_tri = 1'b1;
  endtask

  task automatic run_walk(input string name, input logic [215:0] t, input logic [71:0] c);
    int n = qx.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) valid_tri = 1'b0;
      tests++;
      if (valid_samp !== 1'b1) begin
        fails++; $display("FAIL %s valid[%0d]: got %b want 1", name, i, valid_samp);
      end
      tests++;
      if (sample[0] !== qx[i] || sample[1] !== qy[i]) begin
        fails++;
        $display("FAIL %s sample[%0d]: got (%0d,%0d) want (%0d,%0d)", name, i,
                 $signed(sample[0]), $signed(sample[1]), $signed(qx[i]), $signed(qy[i]));
      end
      tests++;
      if (halt !== (i != n - 1)) begin
        fails++; $display("FAIL %s halt[%0d]: got %b want %b", name, i, halt, (i != n - 1));
      end
      tests++;
      if (tri_out !== t || col_out !== c) begin
        fails++; $display("FAIL %s passthru[%0d]: got %h/%h want %h/%h", name, i, tri_out, col_out, t, c);
      end
    end
    @(negedge clk);
    tests++;
    if (valid_samp !== 1'b0 || halt !== 1'b0) begin
      fails++; $display("FAIL %s end: got valid=%b halt=%b want 0 0", name, valid_samp, halt);
    end
    qx.delete(); qy.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_tri = 1'b0; ss = 2'd0; tri_in = '0; col_in = '0; box = '0;
    @(negedge clk);
    tests++;
    if (valid_samp !== 1'b0 || halt !== 1'b0) begin
      fails++; $display("FAIL reset flags: got valid=%b halt=%b want 0 0", valid_samp, halt);
    end
    tests++;
    if (sample !== '0 || tri_out !== '0 || col_out !== '0) begin
      fails++; $display("FAIL reset data: got %h %h %h want 0", sample, tri_out, col_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_point();
    present(1024, 1024, 1024, 1024, 2'd0, TRI_A, COL_A);
    qx = '{24'd1024}; qy = '{24'd1024};
    run_walk("single", TRI_A, COL_A);
  endtask

  task automatic test_2x2();
    present(0, 0, 1024, 1024, 2'd0, TRI_B, COL_B);
    qx = '{24'd0, 24'd1024, 24'd0, 24'd1024};
    qy = '{24'd0, 24'd0, 24'd1024, 24'd1024};
    run_walk("2x2", TRI_B, COL_B);
  endtask

  task automatic test_half_step();
    present(0, 0, 1024, 1024, 2'd1, TRI_C, COL_C);
    qx = '{24'd0, 24'd512, 24'd1024, 24'd0, 24'd512, 24'd1024, 24'd0, 24'd512, 24'd1024};
    qy = '{24'd0, 24'd0, 24'd0, 24'd512, 24'd512, 24'd512, 24'd1024, 24'd1024, 24'd1024};
    run_walk("half", TRI_C, COL_C);
  endtask

  task automatic test_boundaries();
    // ur = (1.5, 0.7) unaligned
    present(0, 0, 1536, 716, 2'd0, TRI_A, COL_A);
    qx = '{24'd0, 24'd1024}; qy = '{24'd0, 24'd0};
    run_walk("unaligned", TRI_A, COL_A);
    // ur_x < ll_x with tall y: still one sample at ll
    present(1024, 0, 0, 4096, 2'd0, TRI_B, COL_B);
    qx = '{24'd1024}; qy = '{24'd0};
    run_walk("inverted", TRI_B, COL_B);
    // negative coordinates
    present(-1024, -1024, 0, -1024, 2'd0, TRI_C, COL_C);
    qx = '{24'hFFFC00, 24'd0}; qy = '{24'hFFFC00, 24'hFFFC00};
    run_walk("negative", TRI_C, COL_C);
    // x+step would wrap at 24 bits
    present(8387584, 0, 8388607, 0, 2'd0, TRI_A, COL_A);
    qx = '{24'd8387584}; qy = '{24'd0};
    run_walk("poslimit", TRI_A, COL_A);
  endtask

  task automatic test_back_to_back();
    logic [23:0] ex[4] = '{24'd0, 24'd1024, 24'd0, 24'd1024};
    logic [23:0] ey[4] = '{24'd0, 24'd0, 24'd1024, 24'd1024};
    present(0, 0, 1024, 1024, 2'd0, TRI_A, COL_A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) present(2048, 2048, 2048, 2048, 2'd0, TRI_B, COL_B);
      tests++;
      if (valid_samp !== 1'b1 || sample[0] !== ex[i] || sample[1] !== ey[i] || tri_out !== TRI_A) begin
        fails++;
        $display("FAIL b2b A[%0d]: got v=%b (%0d,%0d) tri=%h want v=1 (%0d,%0d) tri=%h", i,
                 valid_samp, sample[0], sample[1], tri_out, ex[i], ey[i], TRI_A);
      end
      tests++;
      if (halt !== (i != 3)) begin
        fails++; $display("FAIL b2b halt[%0d]: got %b want %b", i, halt, (i != 3));
      end
    end
    @(negedge clk);
    valid_tri = 1'b0;
    tests++;
    if (valid_samp !== 1'b1 || sample[0] !== 24'd2048 || sample[1] !== 24'd2048 ||
        tri_out !== TRI_B || col_out !== COL_B) begin
      fails++;
      $display("FAIL b2b B first: got v=%b (%0d,%0d) tri=%h col=%h want v=1 (2048,2048) tri=%h col=%h",
               valid_samp, sample[0], sample[1], tri_out, col_out, TRI_B, COL_B);
    end
    @(negedge clk);
    tests++;
    if (valid_samp !== 1'b0) begin
      fails++; $display("FAIL b2b end: got valid=%b want 0", valid_samp);
    end
  endtask

  task automatic test_halt_ignore();
    logic [23:0] ex[4] = '{24'd0, 24'd1024, 24'd0, 24'd1024};
    logic [23:0] ey[4] = '{24'd0, 24'd0, 24'd1024, 24'd1024};
    present(0, 0, 1024, 1024, 2'd0, TRI_A, COL_A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) present(-5000, 300, 9000, 9000, 2'd3, TRI_C, COL_C);
      if (i == 2) valid_tri = 1'b0;
      tests++;
      if (valid_samp !== 1'b1 || sample[0] !== ex[i] || sample[1] !== ey[i] ||
          tri_out !== TRI_A || col_out !== COL_A) begin
        fails++;
        $display("FAIL hold walk[%0d]: got v=%b (%0d,%0d) tri=%h want v=1 (%0d,%0d) tri=%h", i,
                 valid_samp, sample[0], sample[1], tri_out, ex[i], ey[i], TRI_A);
      end
    end
    @(negedge clk);
    tests++;
    if (valid_samp !== 1'b0 || halt !== 1'b0 || sample[0] !== 24'd1024 ||
        sample[1] !== 24'd1024 || tri_out !== TRI_A) begin
      fails++;
      $display("FAIL hold wait: got v=%b h=%b (%0d,%0d) tri=%h want v=0 h=0 (1024,1024) tri=%h",
               valid_samp, halt, sample[0], sample[1], tri_out, TRI_A);
    end
  endtask

  task automatic test_reset_mid_walk();
    present(0, 0, 1024, 1024, 2'd0, TRI_B, COL_B);
    @(negedge clk);
    valid_tri = 1'b0;
    @(negedge clk);
    tests++;
    if (sample[0] !== 24'd1024 || sample[1] !== 24'd0 || halt !== 1'b1) begin
      fails++; $display("FAIL rstmid pre: got (%0d,%0d) h=%b want (1024,0) h=1", sample[0], sample[1], halt);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (valid_samp !== 1'b0 || halt !== 1'b0 || sample !== '0 || tri_out !== '0 || col_out !== '0) begin
      fails++;
      $display("FAIL rstmid async: got v=%b h=%b s=%h tri=%h col=%h want all 0",
               valid_samp, halt, sample, tri_out, col_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    present(3072, 1024, 4096, 1024, 2'd0, TRI_C, COL_C);
    qx = '{24'd3072, 24'd4096}; qy = '{24'd1024, 24'd1024};
    run_walk("rstmid new", TRI_C, COL_C);
  endtask

  initial begin
    test_reset();
    test_single_point();
    test_2x2();
    test_half_step();
    test_boundaries();
    test_back_to_back();
    test_halt_ignore();
    test_reset_mid_walk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
